// File: rtl/oled_msg_streamer_pkg.sv
// -----------------------------------------------------------------------------
// oled_msg_streamer_pkg
// Shared definitions for the OLED message streamer: FSM state encoding,
// default widths/sizes, a few ASCII constants and the byte-select helper used
// to pick byte N out of the packed message parameter.
// -----------------------------------------------------------------------------
package oled_msg_streamer_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_MSG_LEN    = 5;
   localparam int DEF_GAP_CYCLES = 16;

   localparam logic [7:0] ASCII_A = 8'h41;
   localparam logic [7:0] ASCII_H = 8'h68;
   localparam logic [7:0] ASCII_E = 8'h65;
   localparam logic [7:0] ASCII_L = 8'h6C;
   localparam logic [7:0] ASCII_O = 8'h6F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Byte 0 is the most significant byte of the packed message (first
   // character of a string literal), so byte idx starts at this bit offset.
   function automatic int msg_lsb(input int idx, input int msg_len, input int data_w);
      return (msg_len - 1 - idx) * data_w;
   endfunction

endpackage

// File: rtl/oled_msg_streamer_if.sv
// -----------------------------------------------------------------------------
// oled_msg_streamer_if
// Byte-sink link between the streamer and oled_controller.
//   data_out     : byte to the sink, valid while write_enable is high
//   write_enable : one-cycle strobe per byte
//   buffer_full  : sink backpressure, no byte may be issued while high
// Modports: master = streamer side, slave = sink side.
// -----------------------------------------------------------------------------
interface oled_msg_streamer_if
   import oled_msg_streamer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic [DATA_W-1:0] data_out;
   logic              write_enable;
   logic              buffer_full;

   modport master (output data_out, output write_enable, input buffer_full);
   modport slave  (input data_out, input write_enable, output buffer_full);
endinterface

// File: rtl/oled_msg_streamer.sv
// -----------------------------------------------------------------------------
// oled_msg_streamer
// Streams a compile-time message of MSG_LEN bytes to a byte sink as one-cycle
// write strobes, honouring sink backpressure. Supports one-shot or looping
// operation with a programmable inter-message gap, abort, and busy/done status.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : level-sampled; begins a message when idle
//   loop_en    : repeat the message; sampled on the last-byte edge only
//   abort      : return to idle at the next edge, no done pulse
//   sink       : master side of the byte-sink link (data/strobe/backpressure)
//   busy       : high while a message is in progress, including the done cycle
//   done       : one-cycle pulse after the final byte of a non-looping message
//   byte_idx   : index of the next byte to send
// All outputs are registered.
// -----------------------------------------------------------------------------
module oled_msg_streamer
   import oled_msg_streamer_pkg::*;
#(
   parameter int                        MSG_LEN    = DEF_MSG_LEN,
   parameter int                        DATA_W     = DEF_DATA_W,
   parameter logic [MSG_LEN*DATA_W-1:0] MSG        = "hello",
   parameter int                        GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int                        IDX_W      = $clog2(MSG_LEN) + 1,
   parameter int                        GAP_W      = $clog2(GAP_CYCLES + 1) + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      loop_en,
   input  logic                      abort,
   oled_msg_streamer_if.master       sink,
   output logic                      busy,
   output logic                      done,
   output logic [IDX_W-1:0]          byte_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

   state_t            state_q;
   logic [DATA_W-1:0] data_q;
   logic              we_q;
   logic              busy_q;
   logic              done_q;
   logic [IDX_W-1:0]  idx_q;
   logic [GAP_W-1:0]  gap_q;
   logic [DATA_W-1:0] msg_byte;

   always_comb begin
      msg_byte = MSG[msg_lsb(int'(idx_q), MSG_LEN, DATA_W) +: DATA_W];
   end

   // NOTE: every register here is assigned with <= so all branches read the
   // pre-edge values; mixing in blocking assignments would create ordering
   // races between the state and its registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         gap_q   <= '0;
      end else if (abort) begin
         // data_q is deliberately held: a byte already strobed stays visible.
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         gap_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               we_q   <= 1'b0;
               done_q <= 1'b0;
               idx_q  <= '0;
               // busy_q is still high during the done pulse cycle, which is
               // spent in IDLE; a start seen then is ignored like any other
               // start while busy.
               if (start && !busy_q) begin
                  state_q <= ST_SEND;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q <= 1'b0;
               end
            end

            ST_SEND: begin
               if (!sink.buffer_full) begin
                  data_q <= msg_byte;
                  we_q   <= 1'b1;
                  if (idx_q == LAST_IDX) begin
                     idx_q <= '0;
                     if (loop_en) begin
                        // With no gap the next pass starts on the very next
                        // edge, giving back-to-back strobes across passes.
                        if (GAP_CYCLES > 0) begin
                           state_q <= ST_GAP;
                           gap_q   <= GAP_W'(GAP_CYCLES);
                        end
                     end else begin
                        state_q <= ST_DONE;
                     end
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  we_q <= 1'b0;
               end
            end

            ST_GAP: begin
               we_q <= 1'b0;
               // Leaving at a count of 1 makes the gap exactly GAP_CYCLES
               // strobe-free cycles, because the first byte of the next pass
               // is issued one edge after re-entering SEND.
               if (gap_q == GAP_W'(1)) begin
                  state_q <= ST_SEND;
                  gap_q   <= '0;
               end else begin
                  gap_q <= gap_q - GAP_W'(1);
               end
            end

            ST_DONE: begin
               we_q    <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               idx_q   <= '0;
               gap_q   <= '0;
            end
         endcase
      end
   end

   assign sink.data_out     = data_q;
   assign sink.write_enable = we_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign byte_idx          = idx_q;

endmodule

// File: tb/tb_oled_msg_streamer.sv
// -----------------------------------------------------------------------------
// tb_oled_msg_streamer
// Self-checking bench for oled_msg_streamer. DUT A streams "hello" with a
// 3-cycle loop gap; DUT B streams the single byte "A" with no gap. Inputs are
// driven on the falling edge and outputs sampled on the following falling
// edge. A directed vector table, hand-written corner sequences and a random
// phase compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_oled_msg_streamer;
   import oled_msg_streamer_pkg::*;

   localparam int A_LEN = 5;
   localparam int A_GAP = 3;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start_a = 1'b0, loop_a = 1'b0, abort_a = 1'b0;
   logic       busy_a, done_a;
   logic [3:0] idx_a;
   logic       start_b = 1'b0, loop_b = 1'b0, abort_b = 1'b0;
   logic       busy_b, done_b;
   logic [0:0] idx_b;

   oled_msg_streamer_if #(.DATA_W(8)) if_a ();
   oled_msg_streamer_if #(.DATA_W(8)) if_b ();

   oled_msg_streamer #(
      .MSG_LEN(A_LEN), .DATA_W(8), .MSG("hello"), .GAP_CYCLES(A_GAP)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .loop_en(loop_a), .abort(abort_a),
      .sink(if_a), .busy(busy_a), .done(done_a), .byte_idx(idx_a)
   );

   oled_msg_streamer #(
      .MSG_LEN(1), .DATA_W(8), .MSG("A"), .GAP_CYCLES(0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .loop_en(loop_b), .abort(abort_b),
      .sink(if_b), .busy(busy_b), .done(done_b), .byte_idx(idx_b)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] msg_a [A_LEN];

   typedef struct {
      logic       start, loop_en, abort, full;
      logic       we, done, busy;
      logic [3:0] idx;
      logic [7:0] data;
   } vec_t;

   vec_t vecs [13];

   // ---------------------------------------------------------------- helpers
   function automatic vec_t mk(input logic st, input logic le, input logic ab, input logic fl,
                               input logic we, input logic dn, input logic bs,
                               input logic [3:0] idx, input logic [7:0] d);
      vec_t v;
      v.start = st; v.loop_en = le; v.abort = ab; v.full = fl;
      v.we = we; v.done = dn; v.busy = bs; v.idx = idx; v.data = d;
      return v;
   endfunction

   function automatic logic [31:0] pk(input logic we, input logic dn, input logic bs,
                                      input logic [3:0] idx, input logic [7:0] d);
      return {17'd0, we, dn, bs, idx, d};
   endfunction

   function automatic logic [31:0] pack_a();
      return pk(if_a.write_enable, done_a, busy_a, idx_a, if_a.data_out);
   endfunction

   function automatic logic [31:0] pack_b();
      return pk(if_b.write_enable, done_b, busy_b, {3'b000, idx_b}, if_b.data_out);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h ({we,done,busy,idx,data})", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_a(input logic st, input logic le, input logic ab, input logic fl);
      start_a = st; loop_a = le; abort_a = ab; if_a.buffer_full = fl;
   endtask

   // ------------------------------------------------------- reference model
   // Transaction view of DUT A: a queue of bytes still owed to the sink, a
   // count of gap cycles still to sit out, and a flag for a pending done pulse.
   logic [7:0] m_q [$];
   int         m_gap;
   logic       m_fin, m_we, m_done, m_busy;
   int         m_idx;
   logic [7:0] m_data;

   task automatic model_reset();
      m_q.delete();
      m_gap = 0; m_fin = 0; m_we = 0; m_done = 0; m_busy = 0; m_idx = 0; m_data = 8'h00;
   endtask

   task automatic model_fill();
      for (int i = 0; i < A_LEN; i++) m_q.push_back(msg_a[i]);
   endtask

   task automatic model_step(input logic st, input logic le, input logic ab, input logic fl);
      if (ab) begin
         m_q.delete();
         m_gap = 0; m_fin = 0; m_we = 0; m_busy = 0; m_done = 0; m_idx = 0;
         return;
      end
      m_done = m_fin;
      m_we   = 0;
      if (m_fin) begin
         m_fin = 0;
         m_idx = 0;
         return;
      end
      if (m_q.size() == 0 && m_gap == 0) begin
         if (st && !m_busy) begin
            model_fill();
            m_busy = 1;
         end else begin
            m_busy = 0;
         end
         m_idx = 0;
         return;
      end
      if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) model_fill();
         return;
      end
      if (!fl) begin
         m_data = m_q.pop_front();
         m_we   = 1;
         m_idx  = A_LEN - m_q.size();
         if (m_q.size() == 0) begin
            m_idx = 0;
            if (le) begin
               if (A_GAP > 0) m_gap = A_GAP;
               else model_fill();
            end else begin
               m_fin = 1;
            end
         end
      end
   endtask

   function automatic logic [31:0] model_pack();
      return pk(m_we, m_done, m_busy, 4'(m_idx), m_data);
   endfunction

   // ------------------------------------------------------------------ test
   initial begin
      logic st, le, ab, fl;
      msg_a[0] = ASCII_H; msg_a[1] = ASCII_E; msg_a[2] = ASCII_L;
      msg_a[3] = ASCII_L; msg_a[4] = ASCII_O;

      // start, loop, abort, full | we, done, busy, idx, data
      vecs[0]  = mk(T, F, F, F,  F, F, T, 4'd0, 8'h00);
      vecs[1]  = mk(F, F, F, F,  T, F, T, 4'd1, 8'h68);
      vecs[2]  = mk(T, F, F, F,  T, F, T, 4'd2, 8'h65);
      vecs[3]  = mk(F, F, F, T,  F, F, T, 4'd2, 8'h65);
      vecs[4]  = mk(F, F, F, T,  F, F, T, 4'd2, 8'h65);
      vecs[5]  = mk(F, F, F, T,  F, F, T, 4'd2, 8'h65);
      vecs[6]  = mk(F, F, F, F,  T, F, T, 4'd3, 8'h6C);
      vecs[7]  = mk(F, F, F, F,  T, F, T, 4'd4, 8'h6C);
      vecs[8]  = mk(T, F, F, F,  T, F, T, 4'd0, 8'h6F);
      vecs[9]  = mk(F, F, F, F,  F, T, T, 4'd0, 8'h6F);
      vecs[10] = mk(T, F, F, F,  F, F, F, 4'd0, 8'h6F);
      vecs[11] = mk(T, F, T, F,  F, F, F, 4'd0, 8'h6F);
      vecs[12] = mk(F, F, F, F,  F, F, F, 4'd0, 8'h6F);

      if_a.buffer_full = 1'b0;
      if_b.buffer_full = 1'b0;

      // Reset state
      tick();
      tick();
      check("reset_a", pack_a(), 32'd0);
      check("reset_b", pack_b(), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single-byte message looping with no gap: continuous strobe
      start_b = 1'b1; loop_b = 1'b1;
      tick();
      check("b_start", pack_b(), pk(F, F, T, 4'd0, 8'h00));
      start_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("b_stream", pack_b(), pk(T, F, T, 4'd0, ASCII_A));
      end
      if_b.buffer_full = 1'b1;
      tick();
      check("b_full", pack_b(), pk(F, F, T, 4'd0, ASCII_A));
      if_b.buffer_full = 1'b0;
      tick();
      check("b_resume", pack_b(), pk(T, F, T, 4'd0, ASCII_A));
      abort_b = 1'b1;
      tick();
      check("b_abort", pack_b(), pk(F, F, F, 4'd0, ASCII_A));
      abort_b = 1'b0; loop_b = 1'b0;

      // Directed vector table on DUT A
      for (int i = 0; i < 13; i++) begin
         drive_a(vecs[i].start, vecs[i].loop_en, vecs[i].abort, vecs[i].full);
         tick();
         check($sformatf("vec%0d", i), pack_a(),
               pk(vecs[i].we, vecs[i].done, vecs[i].busy, vecs[i].idx, vecs[i].data));
      end

      // Looping with a 3-cycle gap, then abort mid-pass
      drive_a(T, T, F, F);
      tick();
      check("loop_start", pack_a(), pk(F, F, T, 4'd0, 8'h6F));
      start_a = 1'b0;
      for (int k = 0; k < 20; k++) begin
         int p;
         p = k % 8;
         tick();
         if (p < 5)
            check($sformatf("loop%0d", k), pack_a(),
                  pk(T, F, T, (p < 4) ? 4'(p + 1) : 4'd0, msg_a[p]));
         else
            check($sformatf("loop%0d", k), pack_a(), pk(F, F, T, 4'd0, ASCII_O));
      end
      abort_a = 1'b1;
      tick();
      check("loop_abort", pack_a(), pk(F, F, F, 4'd0, ASCII_L));
      abort_a = 1'b0; loop_a = 1'b0;
      tick();
      check("after_abort", pack_a(), pk(F, F, F, 4'd0, ASCII_L));

      // Asynchronous reset between edges mid-message
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_a", pack_a(), 32'd0);
      check("async_rst_b", pack_b(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      model_step(T, F, F, F);
      drive_a(T, F, F, F);
      tick();
      check("restart_start", pack_a(), model_pack());
      model_step(F, F, F, F);
      drive_a(F, F, F, F);
      tick();
      check("restart_first", pack_a(), pk(T, F, T, 4'd1, ASCII_H));

      // Random phase against the reference model
      le = 1'b0;
      for (int n = 0; n < 2500; n++) begin
         st = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) le = ~le;
         ab = ($urandom_range(0, 79) == 0);
         fl = ($urandom_range(0, 2) == 0);
         model_step(st, le, ab, fl);
         drive_a(st, le, ab, fl);
         tick();
         check($sformatf("rand%0d", n), pack_a(), model_pack());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
